axi_rd_sched: RTL
=================

Name: axi_rd_sched

Overview:
- Read-address scheduler that sits in front of the memory controller AR channel and beside the read-data channel block in the MMU AXI wrapper.
- Accepts app-side AR requests and uses a per-request permission result from the MMU to choose one of two paths:
  - Permitted requests are forwarded to the memory controller.
  - Denied requests become a drop command (id/user/len/size sideband) to the read-data channel, which returns DECERR filler beats.
- Tracks outstanding memory bursts so a drop is only issued after all earlier bursts have fully returned, which preserves in-order R responses.

Parameters:
ID_WID, 8, AXI id width
USER_WID, 2, AXI user width
ADDR_WID, 32, AXI address width
MAX_OUTST, 16, maximum memory bursts in flight (range 1..2^CNT_WID-1)
CNT_WID, 5, outstanding-counter width

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
s_arid  in  ID_WID  app AR id
s_araddr  in  ADDR_WID  app AR address
s_arlen  in  8  app AR len (beats-1)
s_arsize  in  3  app AR size
s_aruser  in  USER_WID  app AR user
s_arvalid  in  1  app AR valid
s_arready  out  1  app AR ready
perm_ok  in  1  MMU permission for the current s_ar request, qualified by s_arvalid
m_arid/m_araddr/m_arlen/m_arsize/m_aruser  out  as s_*  memory AR payload (registered)
m_arvalid  out  1  memory AR valid
m_arready  in  1  memory AR ready
mon_rvalid  in  1  memory-side R valid (monitor only)
mon_rready  in  1  memory-side R ready (monitor only)
mon_rlast  in  1  memory-side R last (monitor only)
drop  out  1  drop command to the read-data channel
drop_arid  out  ID_WID  drop id
drop_aruser  out  USER_WID  drop user
drop_arsize  out  3  drop size
drop_arlen  out  8  drop beat COUNT (s_arlen+1, saturated)
drop_done  in  1  level from the read-data channel, high from last filler beat until its handshake
outst_cnt  out  CNT_WID  bursts in flight
len_sat  out  1  sticky: a drop with s_arlen=255 was saturated
drop_stat  out  16  count of drops issued, wraps

Behaviour:
- Reset (synchronous, reset=1 at a clk edge), overriding everything including mid-operation:
  - state=IDLE; outst_cnt=0; drop_stat=0; len_sat=0.
  - m_arvalid=0 and drop=0; all payload and sideband regs =0.
  - In-flight beats are not tracked across reset.
- Derived signals:
  - cap_ok = outst_cnt < MAX_OUTST.
  - s_arready = (state==IDLE) & (~perm_ok | cap_ok). Combinational; s_arready never depends on m_arready.
  - acc = s_arvalid & s_arready.
- Outstanding counter, each cycle:
  - +1 on m_arvalid & m_arready.
  - -1 on mon_rvalid & mon_rready & mon_rlast.
  - Both in the same cycle: unchanged.
  - Neither saturates: overflow is prevented by cap_ok, and underflow is a bench error (assert).
- IDLE state:
  - On acc with perm_ok: latch s_* into m_* regs and go to ISSUE. m_arvalid=1 from the next cycle.
  - On acc with ~perm_ok: latch id/user/size into drop_*; set drop_arlen = (s_arlen==255) ? 255 : s_arlen+1. If s_arlen==255, set len_sat. Go to DRAIN.
- ISSUE state:
  - m_arvalid=1 with payload held stable.
  - On m_arready: m_arvalid=0 next cycle, go to IDLE.
  - Minimum spacing is 2 cycles per request (IDLE accept + ISSUE handshake).
- DRAIN state:
  - Wait for outst_cnt==0, evaluated on the registered value. A final rlast decrement in cycle N gives DROP in cycle N+2.
  - If outst_cnt is already 0 on entry, go to DROP the next cycle.
- DROP state:
  - drop=1 with drop_* held stable.
  - On drop_done=1: drop=0 next cycle, drop_stat+1, go to DONE_WAIT.
- DONE_WAIT state:
  - Hold until drop_done==0, then go to IDLE. This prevents a stale drop_done from completing the next drop.
- Outputs are registered except s_arready.
- Ordering: no new request is accepted outside IDLE, so drops and forwarded reads are strictly in arrival order.
- Boundary conditions:
  - outst_cnt==MAX_OUTST with a permitted request pending: s_arready=0 until a completion.
  - A denied request at the cap is still accepted (drop path needs no slot).
  - drop_done already high on entry to DROP: this is prevented by DONE_WAIT; assert that it never happens.

Test Plan:
- Permitted single read: s_arvalid, perm_ok=1, s_arid=0x5A, s_arlen=3, m_arready=1 → m_arvalid high exactly 1 cycle starting the cycle after accept, m_arid=0x5A, m_arlen=3, outst_cnt 0→1. Four mon beats with last on the 4th → outst_cnt=0.
- Cap: MAX_OUTST=2, two permitted reads with no returns → third request sees s_arready=0. One mon_rlast handshake → accepted next cycle; outst_cnt sequence 2→1→2.
- Drop ordering: one permitted read (arlen=1) outstanding, then a denied read (arid=0x11, arlen=7) → drop stays 0 until 2 cycles after the rlast handshake. Then drop=1 with drop_arid=0x11, drop_arlen=8, held until drop_done.
- Drop handshake: drop_done pulses high for 3 cycles → drop falls the cycle after the first high, drop_stat=1. The next denied request's drop does not assert until drop_done has returned to 0.
- Saturation: denied s_arlen=255 → drop_arlen=255 and len_sat=1, staying set through later traffic until reset.
- Reset mid-ISSUE with m_arready=0: assert reset 1 cycle → next cycle m_arvalid=0, outst_cnt=0, state IDLE, s_arready=1.

Source files
------------

// File: rtl/axi_rd_sched.sv
// axi_rd_sched: read-address scheduler in front of the memory controller AR
// channel. Each app AR request is steered by the MMU permission result:
//   - permitted: forwarded to the memory AR channel (registered payload)
//   - denied:    turned into a drop command for the read-data channel, which
//                returns DECERR filler. The drop is only issued once every
//                earlier memory burst has fully returned, so R stays in order.
//
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   s_ar*               app AR request (valid/ready)
//   perm_ok             MMU permission for the current s_ar request
//   m_ar*               memory AR request (valid/ready, registered)
//   mon_r*              memory R channel, monitored only to count returned bursts
//   drop, drop_*        drop command with sideband, held until drop_done
//   drop_done           level from read-data channel, high from last filler
//                       beat until its handshake
//   outst_cnt           memory bursts in flight
//   len_sat             sticky: a drop with arlen=255 had its count saturated
//   drop_stat           wrapping count of drops issued
//   fsm_state           debug view of the scheduler state
//
// Handshake semantics: every valid/ready pair transfers on a clock edge where
// both are high; a source keeps valid and payload stable until that edge.
module axi_rd_sched #(
  parameter int ID_WID    = 8,
  parameter int USER_WID  = 2,
  parameter int ADDR_WID  = 32,
  parameter int MAX_OUTST = 16,
  parameter int CNT_WID   = 5
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [ID_WID-1:0]   s_arid,
  input  logic [ADDR_WID-1:0] s_araddr,
  input  logic [7:0]          s_arlen,
  input  logic [2:0]          s_arsize,
  input  logic [USER_WID-1:0] s_aruser,
  input  logic                s_arvalid,
  output logic                s_arready,
  input  logic                perm_ok,
  output logic [ID_WID-1:0]   m_arid,
  output logic [ADDR_WID-1:0] m_araddr,
  output logic [7:0]          m_arlen,
  output logic [2:0]          m_arsize,
  output logic [USER_WID-1:0] m_aruser,
  output logic                m_arvalid,
  input  logic                m_arready,
  input  logic                mon_rvalid,
  input  logic                mon_rready,
  input  logic                mon_rlast,
  output logic                drop,
  output logic [ID_WID-1:0]   drop_arid,
  output logic [USER_WID-1:0] drop_aruser,
  output logic [2:0]          drop_arsize,
  output logic [7:0]          drop_arlen,
  input  logic                drop_done,
  output logic [CNT_WID-1:0]  outst_cnt,
  output logic                len_sat,
  output logic [15:0]         drop_stat,
  output logic [2:0]          fsm_state
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ISSUE     = 3'd1,
    DRAIN     = 3'd2,
    DROP      = 3'd3,
    DONE_WAIT = 3'd4
  } state_t;

  state_t state;
  logic   cap_ok;
  logic   acc;
  logic   inc;
  logic   dec;

  // A denied request needs no memory slot, so only permitted ones are gated
  // by the outstanding cap.
  assign cap_ok    = outst_cnt < CNT_WID'(MAX_OUTST);
  assign s_arready = (state == IDLE) & (~perm_ok | cap_ok);
  assign acc       = s_arvalid & s_arready;
  assign inc       = m_arvalid & m_arready;
  assign dec       = mon_rvalid & mon_rready & mon_rlast;
  assign fsm_state = state;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      outst_cnt   <= '0;
      drop_stat   <= '0;
      len_sat     <= 1'b0;
      m_arvalid   <= 1'b0;
      m_arid      <= '0;
      m_araddr    <= '0;
      m_arlen     <= '0;
      m_arsize    <= '0;
      m_aruser    <= '0;
      drop        <= 1'b0;
      drop_arid   <= '0;
      drop_aruser <= '0;
      drop_arsize <= '0;
      drop_arlen  <= '0;
    end else begin
      if (inc && !dec) begin
        outst_cnt <= outst_cnt + CNT_WID'(1);
      end else if (dec && !inc) begin
        outst_cnt <= outst_cnt - CNT_WID'(1);
      end

      case (state)
        IDLE: begin
          if (acc) begin
            if (perm_ok) begin
              m_arid    <= s_arid;
              m_araddr  <= s_araddr;
              m_arlen   <= s_arlen;
              m_arsize  <= s_arsize;
              m_aruser  <= s_aruser;
              m_arvalid <= 1'b1;
              state     <= ISSUE;
            end else begin
              drop_arid   <= s_arid;
              drop_aruser <= s_aruser;
              drop_arsize <= s_arsize;
              // drop_arlen is a beat count; 256 beats does not fit in 8 bits.
              if (s_arlen == 8'd255) begin
                drop_arlen <= 8'd255;
                len_sat    <= 1'b1;
              end else begin
                drop_arlen <= s_arlen + 8'd1;
              end
              state <= DRAIN;
            end
          end
        end
        ISSUE: begin
          if (m_arready) begin
            m_arvalid <= 1'b0;
            state     <= IDLE;
          end
        end
        DRAIN: begin
          // Registered count: the last rlast decrement lands a cycle before
          // this comparison sees zero.
          if (outst_cnt == '0) begin
            drop  <= 1'b1;
            state <= DROP;
          end
        end
        DROP: begin
          if (drop_done) begin
            drop      <= 1'b0;
            drop_stat <= drop_stat + 16'd1;
            state     <= DONE_WAIT;
          end
        end
        DONE_WAIT: begin
          // drop_done is a level; wait for it to fall so it cannot complete
          // the next drop.
          if (!drop_done) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      assert (!(dec && !inc && outst_cnt == '0));
      assert (!(state == DRAIN && outst_cnt == '0 && drop_done));
    end
  end

endmodule
